lr35902_irq_ctrl: RTL and testbench

- Interrupt controller directly downstream of the PPU.
- Consumes irq_vblank and irq_stat, plus the timer, serial and joypad request lines.
- Latches rising edges into IF (FF0F), masks them with IE (FFFF), and presents the highest-priority pending request and its vector to the CPU core.
- Completes a one-cycle acknowledge handshake that clears the serviced IF bit.

---
 rtl/lr35902_irq_pkg.sv | 38 +++
 rtl/lr35902_irq_edge.sv | 39 +++
 rtl/lr35902_irq_ctrl.sv | 97 +++++++++
 tb/tb_lr35902_irq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lr35902_irq_pkg.sv
// rtl/lr35902_irq_pkg.sv - shared constants and priority helpers for the LR35902 interrupt controller
package lr35902_irq_pkg;

   localparam int NUM_IRQ    = 5;
   localparam int IRQ_VBLANK = 0;
   localparam int IRQ_STAT   = 1;
   localparam int IRQ_TIMER  = 2;
   localparam int IRQ_SERIAL = 3;
   localparam int IRQ_JOYPAD = 4;

   localparam logic [7:0] DEF_IF_ADR   = 8'h0f;
   localparam logic [7:0] DEF_IE_ADR   = 8'hff;
   localparam logic [7:0] DEF_VEC_BASE = 8'h40;

   // Unimplemented upper IF bits read back as ones.
   localparam logic [2:0] IF_PAD = 3'b111;

   typedef logic [NUM_IRQ-1:0] irq_vec_t;

   function automatic logic [2:0] irq_lowest(input irq_vec_t v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   function automatic irq_vec_t irq_onehot(input logic [2:0] idx);
      irq_vec_t m;
      m = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (idx == 3'(i)) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/lr35902_irq_edge.sv
// rtl/lr35902_irq_edge.sv - per-source rising-edge detector; LR35902_IRQ_SYNC_EN adds a 2-flop synchronizer
module lr35902_irq_edge (
   input  logic clk,
   input  logic reset,
   input  logic src,
   output logic rise
);

   logic src_s;
   logic prev;

`ifdef LR35902_IRQ_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], src};
      end
   end

   assign src_s = sync_q[1];
`else
   assign src_s = src;
`endif

   // prev resets low so a source already high at reset release counts as an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev <= 1'b0;
      end else begin
         prev <= src_s;
      end
   end

   assign rise = src_s & ~prev;

endmodule

// File: rtl/lr35902_irq_ctrl.sv
// rtl/lr35902_irq_ctrl.sv - IF/IE interrupt controller with vector output; LR35902_IRQ_SYNC_EN synchronizes sources
module lr35902_irq_ctrl
   import lr35902_irq_pkg::*;
#(
   parameter logic [7:0] VEC_BASE = DEF_VEC_BASE,
   parameter logic [7:0] IF_ADR   = DEF_IF_ADR,
   parameter logic [7:0] IE_ADR   = DEF_IE_ADR
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] dout,
   input  logic [7:0] din,
   input  logic [7:0] adr,
   input  logic       read,
   input  logic       write,
   input  logic       irq_vblank,
   input  logic       irq_stat,
   input  logic       irq_timer,
   input  logic       irq_serial,
   input  logic       irq_joypad,
   output logic       int_req,
   output logic [7:0] int_vec,
   input  logic       int_ack
);

   irq_vec_t   src;
   irq_vec_t   rise;
   irq_vec_t   if_r;
   irq_vec_t   if_nxt;
   irq_vec_t   pend;
   irq_vec_t   ack_mask;
   logic [7:0] ie_r;
   logic [7:0] rd_data;
   logic [2:0] pend_idx;
   logic       if_wr;
   logic       ie_wr;

   assign src[IRQ_VBLANK] = irq_vblank;
   assign src[IRQ_STAT]   = irq_stat;
   assign src[IRQ_TIMER]  = irq_timer;
   assign src[IRQ_SERIAL] = irq_serial;
   assign src[IRQ_JOYPAD] = irq_joypad;

   for (genvar n = 0; n < NUM_IRQ; n++) begin : g_edge
      lr35902_irq_edge u_edge (
         .clk   (clk),
         .reset (reset),
         .src   (src[n]),
         .rise  (rise[n])
      );
   end

   assign pend     = if_r & ie_r[NUM_IRQ-1:0];
   assign pend_idx = irq_lowest(pend);
   assign int_req  = |pend;
   assign int_vec  = VEC_BASE + {2'b00, pend_idx, 3'b000};

   assign if_wr    = write && (adr == IF_ADR);
   assign ie_wr    = write && (adr == IE_ADR);
   assign ack_mask = (int_ack && int_req) ? irq_onehot(pend_idx) : '0;

   // Edges are ORed in last so a new request is never lost to a write or ack.
   always_comb begin
      if_nxt = if_r;
      if (if_wr) begin
         if_nxt = din[NUM_IRQ-1:0];
      end
      if_nxt = if_nxt & ~ack_mask;
      if_nxt = if_nxt | rise;
   end

   always_comb begin
      rd_data = 8'hff;
      if (adr == IF_ADR) begin
         rd_data = {IF_PAD, if_r};
      end else if (adr == IE_ADR) begin
         rd_data = ie_r;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_r <= '0;
         ie_r <= 8'h00;
         dout <= 8'hff;
      end else begin
         if_r <= if_nxt;
         if (ie_wr) begin
            ie_r <= din;
         end
         if (read) begin
            dout <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_lr35902_irq_ctrl.sv
// tb/tb_lr35902_irq_ctrl.sv - self-checking bench for lr35902_irq_ctrl
module tb_lr35902_irq_ctrl;

`ifdef LR35902_IRQ_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] dout;
   logic [7:0] din = 8'h00;
   logic [7:0] adr = 8'h00;
   logic       read = 1'b0;
   logic       write = 1'b0;
   logic [4:0] src = 5'h00;
   logic       int_req;
   logic [7:0] int_vec;
   logic       int_ack = 1'b0;

   int total = 0;
   int bad = 0;

   logic [4:0] m_if;
   logic [7:0] m_ie;
   logic [7:0] m_dout;
   logic [4:0] hist [4];

   typedef struct {
      logic       rd;
      logic       wr;
      logic [7:0] adr;
      logic [7:0] din;
      logic       ack;
      logic       req;
      logic [7:0] vec;
      logic [7:0] dout;
   } row_t;

   row_t tbl [20];

   lr35902_irq_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .dout       (dout),
      .din        (din),
      .adr        (adr),
      .read       (read),
      .write      (write),
      .irq_vblank (src[0]),
      .irq_stat   (src[1]),
      .irq_timer  (src[2]),
      .irq_serial (src[3]),
      .irq_joypad (src[4]),
      .int_req    (int_req),
      .int_vec    (int_vec),
      .int_ack    (int_ack)
   );

   always #5 clk = ~clk;

   task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] lowest_bit(input logic [4:0] v);
      return v & (~v + 5'd1);
   endfunction

   function automatic logic [7:0] model_vec();
      logic [4:0] low;
      logic [7:0] v;
      low = lowest_bit(m_if & m_ie[4:0]);
      v = 8'h40;
      for (int i = 0; i < 5; i++) begin
         if (low == (5'd1 << i)) v = 8'h40 + 8'(8 * i);
      end
      return v;
   endfunction

   task automatic step();
      logic [4:0] rise;
      logic [4:0] nif;
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = src;
      rise = hist[LAT-1] & ~hist[LAT];
      if (read) begin
         if (adr == 8'h0f) m_dout = {3'b111, m_if};
         else if (adr == 8'hff) m_dout = m_ie;
         else m_dout = 8'hff;
      end
      nif = m_if;
      if (write && adr == 8'h0f) nif = din[4:0];
      if (int_ack) nif = nif & ~lowest_bit(m_if & m_ie[4:0]);
      nif = nif | rise;
      if (write && adr == 8'hff) m_ie = din;
      m_if = nif;
      @(posedge clk);
      #1;
      chk1("model_req", int_req, (m_if & m_ie[4:0]) != 5'h00);
      chk8("model_vec", int_vec, model_vec());
      chk8("model_dout", dout, m_dout);
   endtask

   task automatic cyc(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d, input logic ack);
      read = rd;
      write = wr;
      adr = a;
      din = d;
      int_ack = ack;
      step();
      read = 1'b0;
      write = 1'b0;
      int_ack = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      read = 1'b0;
      write = 1'b0;
      int_ack = 1'b0;
      #1;
      chk1("reset_req", int_req, 1'b0);
      chk8("reset_vec", int_vec, 8'h40);
      chk8("reset_dout", dout, 8'hff);
      m_if = 5'h00;
      m_ie = 8'h00;
      m_dout = 8'hff;
      for (int i = 0; i < 4; i++) hist[i] = 5'h00;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic expect_rise(input string nm, input logic [4:0] mask, input logic pulse);
      src = src | mask;
      for (int i = 1; i <= LAT; i++) begin
         step();
         if (pulse && i == 1) src = src & ~mask;
         chk1(nm, int_req, i == LAT);
      end
   endtask

   initial begin
      logic [7:0] a;

      tbl[0]  = '{1'b1, 1'b0, 8'h0f, 8'h00, 1'b0, 1'b0, 8'h40, 8'he0};
      tbl[1]  = '{1'b1, 1'b0, 8'hff, 8'h00, 1'b0, 1'b0, 8'h40, 8'h00};
      tbl[2]  = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h40, 8'hff};
      tbl[3]  = '{1'b0, 1'b1, 8'h0f, 8'h1e, 1'b0, 1'b0, 8'h40, 8'hff};
      tbl[4]  = '{1'b0, 1'b1, 8'hff, 8'h1c, 1'b0, 1'b1, 8'h50, 8'hff};
      tbl[5]  = '{1'b1, 1'b0, 8'h0f, 8'h00, 1'b0, 1'b1, 8'h50, 8'hfe};
      tbl[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h58, 8'hfe};
      tbl[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h60, 8'hfe};
      tbl[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'hfe};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'hfe};
      tbl[10] = '{1'b1, 1'b0, 8'h0f, 8'h00, 1'b0, 1'b0, 8'h40, 8'he2};
      tbl[11] = '{1'b0, 1'b1, 8'hff, 8'hff, 1'b0, 1'b1, 8'h48, 8'he2};
      tbl[12] = '{1'b1, 1'b1, 8'hff, 8'he3, 1'b0, 1'b1, 8'h48, 8'hff};
      tbl[13] = '{1'b1, 1'b0, 8'hff, 8'h00, 1'b0, 1'b1, 8'h48, 8'he3};
      tbl[14] = '{1'b0, 1'b1, 8'h0e, 8'h00, 1'b0, 1'b1, 8'h48, 8'he3};
      tbl[15] = '{1'b0, 1'b1, 8'h0f, 8'hff, 1'b0, 1'b1, 8'h40, 8'he3};
      tbl[16] = '{1'b1, 1'b0, 8'h0f, 8'h00, 1'b0, 1'b1, 8'h40, 8'hff};
      tbl[17] = '{1'b1, 1'b1, 8'h0f, 8'h00, 1'b0, 1'b0, 8'h40, 8'hff};
      tbl[18] = '{1'b1, 1'b0, 8'h0f, 8'h00, 1'b0, 1'b0, 8'h40, 8'he0};
      tbl[19] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'he0};

      #2;
      do_reset();

      // register access, priority and ack walk with quiet sources
      for (int r = 0; r < 20; r++) begin
         cyc(tbl[r].rd, tbl[r].wr, tbl[r].adr, tbl[r].din, tbl[r].ack);
         chk1($sformatf("tbl%0d_req", r), int_req, tbl[r].req);
         chk8($sformatf("tbl%0d_vec", r), int_vec, tbl[r].vec);
         chk8($sformatf("tbl%0d_dout", r), dout, tbl[r].dout);
      end

      // single vblank pulse
      do_reset();
      cyc(1'b0, 1'b1, 8'hff, 8'h01, 1'b0);
      expect_rise("single_rise", 5'h01, 1'b1);
      chk8("single_vec", int_vec, 8'h40);
      cyc(1'b1, 1'b0, 8'h0f, 8'h00, 1'b0);
      chk8("single_if", dout, 8'he1);
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      chk1("single_ack_req", int_req, 1'b0);
      cyc(1'b1, 1'b0, 8'h0f, 8'h00, 1'b0);
      chk8("single_if_clr", dout, 8'he0);

      // stat held high: one request only until it falls and rises again
      do_reset();
      cyc(1'b0, 1'b1, 8'hff, 8'h02, 1'b0);
      expect_rise("level_rise", 5'h02, 1'b0);
      chk8("level_vec", int_vec, 8'h48);
      repeat (7) step();
      chk1("level_still_req", int_req, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      chk1("level_ack", int_req, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk1("level_hold", int_req, 1'b0);
      end
      src[1] = 1'b0;
      for (int i = 0; i <= LAT; i++) begin
         step();
         chk1("level_low", int_req, 1'b0);
      end
      expect_rise("level_rerise", 5'h02, 1'b0);
      src[1] = 1'b0;

      // ack and edge on the same bit; CPU write and edge together
      do_reset();
      cyc(1'b0, 1'b1, 8'hff, 8'h01, 1'b0);
      cyc(1'b0, 1'b1, 8'h0f, 8'h01, 1'b0);
      chk8("coll_vec", int_vec, 8'h40);
      src[0] = 1'b1;
      repeat (LAT - 1) step();
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      chk1("coll_ack_req", int_req, 1'b1);
      cyc(1'b1, 1'b0, 8'h0f, 8'h00, 1'b0);
      chk8("coll_ack_if", dout, 8'he1);
      src[2] = 1'b1;
      repeat (LAT - 1) step();
      cyc(1'b0, 1'b1, 8'h0f, 8'h00, 1'b0);
      cyc(1'b1, 1'b0, 8'h0f, 8'h00, 1'b0);
      chk8("coll_wr_if", dout, 8'he4);

      // reset during a pending ack; vblank still high re-triggers afterwards
      cyc(1'b0, 1'b1, 8'h0f, 8'h1f, 1'b0);
      chk1("mid_req", int_req, 1'b1);
      int_ack = 1'b1;
      do_reset();
      for (int i = 1; i <= LAT; i++) begin
         if (i == 1) cyc(1'b0, 1'b1, 8'hff, 8'h01, 1'b0);
         else step();
         chk1("post_reset_rise", int_req, i == LAT);
      end
      chk8("post_reset_vec", int_vec, 8'h40);

      // joypad latency
      do_reset();
      src = 5'h00;
      cyc(1'b0, 1'b1, 8'hff, 8'h10, 1'b0);
      expect_rise("joypad_rise", 5'h10, 1'b1);
      chk8("joypad_vec", int_vec, 8'h60);

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         for (int b = 0; b < 5; b++) begin
            if ($urandom_range(0, 3) == 0) src[b] = ~src[b];
         end
         case ($urandom_range(0, 3))
            0: a = 8'h0f;
            1: a = 8'hff;
            default: a = 8'($urandom);
         endcase
         cyc($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, a, 8'($urandom),
             $urandom_range(0, 2) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
